// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, state code, mux selects, control word.
// Latency: n/a (types/constants only); backpressure: none.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   // Thirteen live states occupy 0..12; codes 13..15 are unused and behave like RESET.
   typedef enum logic [3:0] {
      ST_RESET   = 4'd0,
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_MEMADDR = 4'd3,
      ST_MEMRD   = 4'd4,
      ST_MEMWB   = 4'd5,
      ST_MEMWR   = 4'd6,
      ST_EXEC    = 4'd7,
      ST_RWB     = 4'd8,
      ST_ADDIEX  = 4'd9,
      ST_ADDIWB  = 4'd10,
      ST_BRANCH  = 4'd11,
      ST_JUMP    = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      ASB_REGB  = 2'b00,
      ASB_FOUR  = 2'b01,
      ASB_IMM   = 2'b10,
      ASB_IMMSH = 2'b11
   } alusrcb_t;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } aluop_t;

   // Matches the 3:1 PC mux: 00 selects input A, 01 input B, 10 input C; 11 is never produced.
   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pcsrc_t;

   typedef struct packed {
      logic     pcwrite;
      logic     pcwritecond;
      logic     iord;
      logic     memread;
      logic     memwrite;
      logic     irwrite;
      logic     memtoreg;
      logic     regdst;
      logic     regwrite;
      logic     alusrca;
      alusrcb_t alusrcb;
      aluop_t   aluop;
      pcsrc_t   pcsource;
      logic     instr_done;
   } ctrl_t;

   function automatic logic op_supported(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: current state to datapath control word, purely combinational.
// Latency: 0 cycles; backpressure: none.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.memread  = 1'b1;
            ctrl.irwrite  = 1'b1;
            ctrl.pcwrite  = 1'b1;
            ctrl.alusrcb  = ASB_FOUR;
            ctrl.aluop    = ALU_ADD;
            ctrl.pcsource = PCSRC_ALU;
         end
         ST_DECODE: begin
            // Speculative branch target PC + (imm << 2) computed while the opcode is examined.
            ctrl.alusrcb = ASB_IMMSH;
            ctrl.aluop   = ALU_ADD;
         end
         ST_MEMADDR, ST_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ASB_IMM;
            ctrl.aluop   = ALU_ADD;
         end
         ST_MEMRD: begin
            ctrl.memread = 1'b1;
            ctrl.iord    = 1'b1;
         end
         ST_MEMWR: begin
            ctrl.memwrite   = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_MEMWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.memtoreg   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_EXEC: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ASB_REGB;
            ctrl.aluop   = ALU_FUNCT;
         end
         ST_RWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.regdst     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_ADDIWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alusrca     = 1'b1;
            ctrl.alusrcb     = ASB_REGB;
            ctrl.aluop       = ALU_SUB;
            ctrl.pcwritecond = 1'b1;
            ctrl.pcsource    = PCSRC_ALUOUT;
            ctrl.instr_done  = 1'b1;
         end
         ST_JUMP: begin
            ctrl.pcwrite    = 1'b1;
            ctrl.pcsource   = PCSRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back, drives datapath selects.
// Latency: outputs are Moore (state only), 3-5 cycles per instruction; backpressure: none.
module mc_control_fsm
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t state_q, state_d;
   logic   is_lw_q;
   logic   illegal_q;
   ctrl_t  ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RESET;
         is_lw_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         // Opcode is only trusted in DECODE; later lw/sw steering uses this captured bit.
         if (state_q == ST_DECODE) begin
            is_lw_q <= (opcode == OP_LW);
            if (!op_supported(opcode))
               illegal_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_RESET:  state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = ST_MEMADDR;
               OP_RTYPE:     state_d = ST_EXEC;
               OP_ADDI:      state_d = ST_ADDIEX;
               OP_BEQ:       state_d = ST_BRANCH;
               OP_J:         state_d = ST_JUMP;
               default:      state_d = ST_FETCH;
            endcase
         end
         ST_MEMADDR: state_d = is_lw_q ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:   state_d = ST_MEMWB;
         ST_EXEC:    state_d = ST_RWB;
         ST_ADDIEX:  state_d = ST_ADDIWB;
         default:    state_d = ST_FETCH;
      endcase
   end

   mc_ctrl_decode u_decode (
      .state (state_q),
      .ctrl  (ctrl)
   );

   assign PCWrite     = ctrl.pcwrite;
   assign PCWriteCond = ctrl.pcwritecond;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.memread;
   assign MemWrite    = ctrl.memwrite;
   assign IRWrite     = ctrl.irwrite;
   assign MemtoReg    = ctrl.memtoreg;
   assign RegDst      = ctrl.regdst;
   assign RegWrite    = ctrl.regwrite;
   assign ALUSrcA     = ctrl.alusrca;
   assign ALUSrcB     = ctrl.alusrcb;
   assign ALUOp       = ctrl.aluop;
   assign PCSource    = ctrl.pcsource;
   assign instr_done  = ctrl.instr_done;
   assign illegal_op  = illegal_q;
   assign state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle vector table plus a mid-instruction reset sequence.
module tb_mc_control_fsm;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   mc_control_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .PCSource    (PCSource),
      .instr_done  (instr_done),
      .illegal_op  (illegal_op),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed as {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
   //            ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],instr_done}
   localparam logic [16:0] C_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_FETCH   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
   localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [16:0] C_MEMADDR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
   localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
   localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
   localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;
   localparam logic [16:0] C_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
   localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;

   localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADDR = 4'd3;
   localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7;
   localparam logic [3:0] S_RWB = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_BRANCH = 4'd11;
   localparam logic [3:0] S_JUMP = 4'd12;

   typedef struct {
      logic [5:0]  op;
      logic [3:0]  st;
      logic [16:0] ctl;
      logic        ill;
   } vec_t;

   vec_t        vecs[$];
   int          checks;
   int          errors;
   int          done_cnt;
   logic [16:0] ctl_act;

   assign ctl_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                     RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic [3:0] st, input logic [16:0] ctl,
                      input logic ill);
      vec_t v;
      v.op = op; v.st = st; v.ctl = ctl; v.ill = ill;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      done_cnt = 0;
      reset    = 1'b1;
      opcode   = 6'h23;

      // opcode driven before each edge, expected state/outputs after it; 0x3F is junk outside DECODE
      add(6'h23, S_FETCH,   C_FETCH,   1'b0);   // lw valid during reset still gives one RESET cycle
      add(6'h3F, S_DECODE,  C_DECODE,  1'b0);
      add(6'h23, S_MEMADDR, C_MEMADDR, 1'b0);
      add(6'h2B, S_MEMRD,   C_MEMRD,   1'b0);   // sw opcode after DECODE must not redirect lw
      add(6'h3F, S_MEMWB,   C_MEMWB,   1'b0);
      add(6'h00, S_FETCH,   C_FETCH,   1'b0);
      add(6'h3F, S_DECODE,  C_DECODE,  1'b0);   // R-type
      add(6'h00, S_EXEC,    C_EXEC,    1'b0);
      add(6'h3F, S_RWB,     C_RWB,     1'b0);
      add(6'h3F, S_FETCH,   C_FETCH,   1'b0);
      add(6'h3F, S_DECODE,  C_DECODE,  1'b0);   // sw back-to-back
      add(6'h2B, S_MEMADDR, C_MEMADDR, 1'b0);
      add(6'h23, S_MEMWR,   C_MEMWR,   1'b0);
      add(6'h3F, S_FETCH,   C_FETCH,   1'b0);
      add(6'h3F, S_DECODE,  C_DECODE,  1'b0);   // beq
      add(6'h04, S_BRANCH,  C_BRANCH,  1'b0);
      add(6'h3F, S_FETCH,   C_FETCH,   1'b0);
      add(6'h3F, S_DECODE,  C_DECODE,  1'b0);   // j
      add(6'h02, S_JUMP,    C_JUMP,    1'b0);
      add(6'h3F, S_FETCH,   C_FETCH,   1'b0);
      add(6'h00, S_DECODE,  C_DECODE,  1'b0);   // illegal 0x3F
      add(6'h3F, S_FETCH,   C_FETCH,   1'b1);
      add(6'h3F, S_DECODE,  C_DECODE,  1'b1);   // addi, flag stays set
      add(6'h08, S_ADDIEX,  C_MEMADDR, 1'b1);
      add(6'h3F, S_ADDIWB,  C_ADDIWB,  1'b1);
      add(6'h3F, S_FETCH,   C_FETCH,   1'b1);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(state), 32'(S_RESET));
      chk("reset_ctl", 32'(ctl_act), 32'(C_ZERO));
      chk("reset_illegal", 32'(illegal_op), 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         opcode = vecs[i].op;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
         chk($sformatf("v%0d_ctl", i), 32'(ctl_act), 32'(vecs[i].ctl));
         chk($sformatf("v%0d_illegal", i), 32'(illegal_op), 32'(vecs[i].ill));
         if (instr_done) done_cnt++;
      end
      chk("instr_done_pulses", 32'(done_cnt), 32'd6);

      // sw up to MEMWR, then reset mid-cycle: write strobe must drop at once
      opcode = 6'h3F;
      @(posedge clk); #1;
      chk("seq_decode", 32'(state), 32'(S_DECODE));
      opcode = 6'h2B;
      @(posedge clk); #1;
      opcode = 6'h3F;
      @(posedge clk); #1;
      chk("seq_memwr_state", 32'(state), 32'(S_MEMWR));
      chk("seq_memwr_memwrite", 32'(MemWrite), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_memwrite", 32'(MemWrite), 32'd0);
      chk("abort_state", 32'(state), 32'(S_RESET));
      chk("abort_ctl", 32'(ctl_act), 32'(C_ZERO));
      chk("abort_illegal_cleared", 32'(illegal_op), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_fetch", 32'(state), 32'(S_FETCH));
      chk("post_reset_fetch_ctl", 32'(ctl_act), 32'(C_FETCH));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
